// File: rtl/timer_apb_slave.sv
// APB register file for the 8-bit timer: TDR/TCR/TSR, sticky OVF/UDF flags,
// and a configurable number of wait states in the ACCESS phase.
module timer_apb_slave #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [7:0]        pwdata,
  output logic [7:0]        prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [7:0]        tdr_o,
  output logic              load_o,
  output logic              updw_o,
  output logic              en_o,
  output logic [1:0]        cks_o,
  input  logic              ovf_i,
  input  logic              udf_i,
  output logic [1:0]        tsr_o
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  state_t      state, state_nx;
  logic [2:0]  wcnt;
  logic [7:0]  tdr, tcr;
  logic [1:0]  tsr, tsr_clr;
  logic        addr_err, wr_en;

  assign addr_err = (paddr > ADDR_W'(2));
  assign wr_en    = pready && pwrite && !addr_err;

  // State register and wait counter
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nx;
      if (state == SETUP && state_nx == ACCESS)
        wcnt <= WS;
      else if (state == ACCESS && wcnt != '0)
        wcnt <= wcnt - 3'd1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (psel && !penable) state_nx = SETUP;
      SETUP:   if (!psel) state_nx = IDLE;
               else if (penable) state_nx = ACCESS;
      ACCESS:  if (!psel) state_nx = IDLE;
               else if (pready) state_nx = (psel && !penable) ? SETUP : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Completion is gated by the live bus so a dropped psel never sees pready
  always_comb begin
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    if (state == ACCESS && wcnt == '0 && psel && penable) begin
      pready  = 1'b1;
      pslverr = addr_err;
      if (!pwrite && !addr_err) begin
        case (paddr[1:0])
          2'd0:    prdata = tdr;
          2'd1:    prdata = tcr;
          default: prdata = {6'b0, tsr};
        endcase
      end
    end
  end

  assign tsr_clr = (wr_en && paddr == ADDR_W'(2)) ? ~pwdata[1:0] : '0;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tdr <= '0;
      tcr <= '0;
      tsr <= '0;
    end else begin
      if (wr_en && paddr == ADDR_W'(0)) tdr <= pwdata;
      if (wr_en && paddr == ADDR_W'(1)) tcr <= pwdata & 8'hB3;
      // Hardware set takes priority over a same-cycle software clear
      tsr <= (tsr & ~tsr_clr) | {udf_i, ovf_i};
    end
  end

  assign tdr_o  = tdr;
  assign load_o = tcr[7];
  assign updw_o = tcr[5];
  assign en_o   = tcr[4];
  assign cks_o  = tcr[1:0];
  assign tsr_o  = tsr;

endmodule

// File: tb/tb_timer_apb_slave.sv
// Directed bench for timer_apb_slave: one instance with 1 wait state, one with 3.
module tb_timer_apb_slave;

  logic       pclk = 1'b0;
  logic       presetn = 1'b0;
  logic       psel1 = 1'b0, psel3 = 1'b0;
  logic       penable = 1'b0, pwrite = 1'b0;
  logic [7:0] paddr = '0, pwdata = '0;
  logic       ovf_i = 1'b0, udf_i = 1'b0;

  logic [7:0] prdata1, prdata3, tdr1, tdr3;
  logic       pready1, pready3, pslverr1, pslverr3;
  logic       load1, load3, updw1, updw3, en1, en3;
  logic [1:0] cks1, cks3, tsr1, tsr3;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  always #5 pclk = ~pclk;

  timer_apb_slave #(.WAIT_STATES(1), .ADDR_W(8)) dut1 (
    .pclk(pclk), .presetn(presetn), .psel(psel1), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata1),
    .pready(pready1), .pslverr(pslverr1), .tdr_o(tdr1), .load_o(load1),
    .updw_o(updw1), .en_o(en1), .cks_o(cks1), .ovf_i(ovf_i), .udf_i(udf_i),
    .tsr_o(tsr1)
  );

  timer_apb_slave #(.WAIT_STATES(3), .ADDR_W(8)) dut3 (
    .pclk(pclk), .presetn(presetn), .psel(psel3), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata3),
    .pready(pready3), .pslverr(pslverr3), .tdr_o(tdr3), .load_o(load3),
    .updw_o(updw3), .en_o(en3), .cks_o(cks3), .ovf_i(ovf_i), .udf_i(udf_i),
    .tsr_o(tsr3)
  );

  // One APB transfer; optional flag pulses coincide with the completion cycle
  task automatic apb_xfer(input bit sel3, input bit wr, input logic [7:0] addr,
                          input logic [7:0] data, input bit ovf_done, input bit udf_done,
                          output logic [7:0] rdata, output logic slverr,
                          output int unsigned waits);
    bit got = 0;
    @(negedge pclk);
    psel1 = !sel3; psel3 = sel3; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = data;
    @(negedge pclk);
    penable = 1'b1;
    waits = 0; rdata = '0; slverr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      waits++;
      if (sel3 ? pready3 : pready1) begin got = 1; break; end
    end
    n_total++;
    if (!got) $display("FAIL xfer_timeout addr=%02h: pready never rose within %0d cycles", addr, waits);
    else n_pass++;
    rdata  = sel3 ? prdata3 : prdata1;
    slverr = sel3 ? pslverr3 : pslverr1;
    ovf_i = ovf_done; udf_i = udf_done;
    @(posedge pclk); #1;
    psel1 = 1'b0; psel3 = 1'b0; penable = 1'b0; ovf_i = 1'b0; udf_i = 1'b0;
  endtask

  task automatic pulse_udf();
    @(negedge pclk); udf_i = 1'b1;
    @(negedge pclk); udf_i = 1'b0;
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    repeat (2) @(negedge pclk);
    n_total++;
    if ({tdr1, load1, updw1, en1, cks1, tsr1} !== 15'h0)
      $display("FAIL reset_regs: got tdr=%02h ctl=%b tsr=%b, want all 0", tdr1, {load1, updw1, en1, cks1}, tsr1);
    else n_pass++;
    n_total++;
    if ({pready1, pslverr1, prdata1} !== 10'h0)
      $display("FAIL reset_bus: got pready=%b pslverr=%b prdata=%02h, want 0", pready1, pslverr1, prdata1);
    else n_pass++;
    presetn = 1'b1;
    @(negedge pclk);
  endtask

  task automatic test_tdr_tcr();
    logic [7:0] rd; logic se; int unsigned w;
    apb_xfer(0, 1, 8'h00, 8'hFF, 0, 0, rd, se, w);
    n_total++;
    if (w !== 2) $display("FAIL ws1_latency: got %0d cycles, want 2", w); else n_pass++;
    apb_xfer(0, 1, 8'h01, 8'h80, 0, 0, rd, se, w);
    n_total++;
    if ({tdr1, load1, en1} !== {8'hFF, 1'b1, 1'b0})
      $display("FAIL load_cfg: got tdr=%02h load=%b en=%b, want FF 1 0", tdr1, load1, en1);
    else n_pass++;
    apb_xfer(0, 0, 8'h01, 8'h00, 0, 0, rd, se, w);
    n_total++;
    if ({rd, se} !== {8'h80, 1'b0}) $display("FAIL rd_tcr80: got %02h err=%b, want 80 0", rd, se); else n_pass++;
    apb_xfer(0, 1, 8'h01, 8'h30, 0, 0, rd, se, w);
    n_total++;
    if ({load1, en1, updw1, cks1} !== 5'b01100)
      $display("FAIL run_cfg: got load/en/updw/cks=%b, want 01100", {load1, en1, updw1, cks1});
    else n_pass++;
    apb_xfer(0, 0, 8'h01, 8'h00, 0, 0, rd, se, w);
    n_total++;
    if (rd !== 8'h30) $display("FAIL rd_tcr30: got %02h, want 30", rd); else n_pass++;
    apb_xfer(0, 1, 8'h01, 8'hFF, 0, 0, rd, se, w);
    apb_xfer(0, 0, 8'h01, 8'h00, 0, 0, rd, se, w);
    n_total++;
    if ({rd, cks1} !== {8'hB3, 2'b11}) $display("FAIL tcr_mask: got %02h cks=%b, want B3 11", rd, cks1); else n_pass++;
    n_total++;
    if (prdata1 !== 8'h00) $display("FAIL prdata_idle: got %02h, want 00", prdata1); else n_pass++;
  endtask

  task automatic test_flags();
    logic [7:0] rd; logic se; int unsigned w;
    pulse_udf();
    n_total++;
    if (tsr1 !== 2'b10) $display("FAIL udf_set: got %b, want 10", tsr1); else n_pass++;
    apb_xfer(0, 0, 8'h02, 8'h00, 0, 0, rd, se, w);
    n_total++;
    if (rd !== 8'h02) $display("FAIL rd_tsr02: got %02h, want 02", rd); else n_pass++;
    apb_xfer(0, 1, 8'h02, 8'h00, 0, 0, rd, se, w);
    apb_xfer(0, 0, 8'h02, 8'h00, 0, 0, rd, se, w);
    n_total++;
    if ({rd, tsr1} !== {8'h00, 2'b00}) $display("FAIL tsr_clear: got rd=%02h tsr=%b, want 00 00", rd, tsr1); else n_pass++;
    pulse_udf();
    apb_xfer(0, 1, 8'h02, 8'h00, 1, 0, rd, se, w);
    n_total++;
    if (tsr1 !== 2'b01) $display("FAIL set_wins: got %b, want 01", tsr1); else n_pass++;
    apb_xfer(0, 0, 8'h02, 8'h00, 0, 1, rd, se, w);
    n_total++;
    if (rd !== 8'h01) $display("FAIL rd_pre_set: got %02h, want 01", rd); else n_pass++;
    n_total++;
    if (tsr1 !== 2'b11) $display("FAIL udf_during_rd: got %b, want 11", tsr1); else n_pass++;
    apb_xfer(0, 1, 8'h02, 8'h01, 0, 0, rd, se, w);
    n_total++;
    if (tsr1 !== 2'b01) $display("FAIL w1_keeps: got %b, want 01", tsr1); else n_pass++;
  endtask

  task automatic test_error();
    logic [7:0] rd; logic se; int unsigned w;
    apb_xfer(0, 1, 8'h05, 8'h12, 0, 0, rd, se, w);
    n_total++;
    if ({se, rd} !== {1'b1, 8'h00}) $display("FAIL err_wr: got err=%b rd=%02h, want 1 00", se, rd); else n_pass++;
    apb_xfer(0, 0, 8'h05, 8'h00, 0, 0, rd, se, w);
    n_total++;
    if ({se, rd} !== {1'b1, 8'h00}) $display("FAIL err_rd: got err=%b rd=%02h, want 1 00", se, rd); else n_pass++;
    apb_xfer(0, 0, 8'h01, 8'h00, 0, 0, rd, se, w);
    n_total++;
    if ({tdr1, rd, tsr1, se} !== {8'hFF, 8'hB3, 2'b01, 1'b0})
      $display("FAIL err_no_effect: got tdr=%02h tcr=%02h tsr=%b err=%b, want FF B3 01 0", tdr1, rd, tsr1, se);
    else n_pass++;
  endtask

  task automatic test_penable_only();
    bit seen = 0;
    @(negedge pclk); psel1 = 1'b0; penable = 1'b1; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h55;
    repeat (4) begin @(negedge pclk); if (pready1) seen = 1; end
    penable = 1'b0;
    n_total++;
    if ({seen, tdr1} !== {1'b0, 8'hFF}) $display("FAIL penable_only: got ready=%b tdr=%02h, want 0 FF", seen, tdr1); else n_pass++;
  endtask

  task automatic test_wait3_reset();
    logic [7:0] rd; logic se; int unsigned w; bit seen = 0;
    apb_xfer(1, 1, 8'h00, 8'hAA, 0, 0, rd, se, w);
    n_total++;
    if ({w, tdr3} !== {32'd4, 8'hAA}) $display("FAIL ws3_latency: got %0d cycles tdr=%02h, want 4 AA", w, tdr3); else n_pass++;
    @(negedge pclk); psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h01; pwdata = 8'h90;
    @(negedge pclk); penable = 1'b1;
    repeat (2) @(negedge pclk);
    presetn = 1'b0;
    #1;
    n_total++;
    if ({tdr3, tdr1, tsr1, pready3} !== 19'h0)
      $display("FAIL async_reset: got tdr3=%02h tdr1=%02h tsr1=%b pready3=%b, want 0", tdr3, tdr1, tsr1, pready3);
    else n_pass++;
    @(negedge pclk); presetn = 1'b1;
    repeat (6) begin @(negedge pclk); if (pready3) seen = 1; end
    psel3 = 1'b0; penable = 1'b0;
    @(negedge pclk);
    n_total++;
    if ({seen, load3, tdr3} !== 10'h0) $display("FAIL abort_effect: got ready=%b load=%b tdr=%02h, want 0", seen, load3, tdr3); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_tdr_tcr();
    test_flags();
    test_error();
    test_penable_only();
    test_wait3_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
